bus_xfer_ctrl: RTL and testbench

BUS_XFER_CTRL -- requirements
Module: bus_xfer_ctrl

---
 rtl/bus_xfer_ctrl.sv | 146 ++++++++++++++
 tb/tb_bus_xfer_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/bus_xfer_ctrl.sv
// MCU-to-pin-bank bridge: synchronised request, latched command, one bank access, held ack, periodic input scan.
// Latency: ack 4 cycles after mcu_mstr is first sampled (5 if a scan is in flight); MCU waits on fpga_ack, ack drops when request releases.
module bus_xfer_ctrl #(
    parameter int NUM_BANKS   = 17,
    parameter int SCAN_DIV    = 64,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic       CLK50,
    input  logic       rst,
    input  logic       mcu_mstr,
    input  logic [4:0] address,
    input  logic       write_enable,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic       fpga_ready,
    output logic       fpga_ack,
    output logic [4:0] bank_sel,
    output logic       bank_wr,
    output logic [7:0] bank_wdata,
    input  logic [7:0] bank_rdata,
    output logic       sample_en,
    input  logic       err_clr,
    output logic       err_addr,
    output logic       err_timeout
);
    localparam int TW = $clog2(SCAN_DIV);
    localparam int AW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [5:0] NB = 6'(NUM_BANKS);

    typedef enum logic [2:0] {S_IDLE, S_LATCH, S_ACCESS, S_ACK, S_SCAN} state_t;

    state_t          r_state, w_next;
    logic            r_mstr_meta, r_mstr_s;
    logic [4:0]      r_addr, r_scan_ptr;
    logic            r_we, r_scan_pending;
    logic [7:0]      r_wdata, r_data_out;
    logic [AW-1:0]   r_ack_cnt;
    logic [TW-1:0]   r_timer;
    logic            r_err_addr, r_err_timeout;
    logic            w_bad_addr, w_ack_expire;

    assign w_bad_addr   = ({1'b0, address} >= NB);
    assign w_ack_expire = r_mstr_s && (r_ack_cnt == AW'(ACK_TIMEOUT - 1));

    always_ff @(posedge CLK50) begin
        if (rst) begin
            r_mstr_meta <= 1'b0;
            r_mstr_s    <= 1'b0;
        end else begin
            r_mstr_meta <= mcu_mstr;
            r_mstr_s    <= r_mstr_meta;
        end
    end

    always_ff @(posedge CLK50) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (r_mstr_s) w_next = S_LATCH;
                      else if (r_scan_pending) w_next = S_SCAN;
            S_LATCH:  w_next = w_bad_addr ? S_ACK : S_ACCESS;
            S_ACCESS: w_next = S_ACK;
            S_ACK:    if (!r_mstr_s || w_ack_expire) w_next = S_IDLE;
            S_SCAN:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK50) begin
        if (rst) begin
            r_addr         <= '0;
            r_we           <= 1'b0;
            r_wdata        <= '0;
            r_data_out     <= '0;
            r_ack_cnt      <= '0;
            r_timer        <= TW'(SCAN_DIV - 1);
            r_scan_pending <= 1'b0;
            r_scan_ptr     <= '0;
            r_err_addr     <= 1'b0;
            r_err_timeout  <= 1'b0;
        end else begin
            if (r_state == S_LATCH) begin
                r_addr     <= address;
                r_we       <= write_enable;
                r_wdata    <= data_in;
                r_data_out <= 8'h00;
            end
            if (r_state == S_ACCESS && !r_we) r_data_out <= bank_rdata;

            r_ack_cnt <= (r_state == S_ACK) ? r_ack_cnt + 1'b1 : '0;

            // A timer expiry landing on the SCAN cycle must not be swallowed by the clear.
            if (r_timer == '0) begin
                r_timer        <= TW'(SCAN_DIV - 1);
                r_scan_pending <= 1'b1;
            end else begin
                r_timer <= r_timer - 1'b1;
                if (r_state == S_SCAN) r_scan_pending <= 1'b0;
            end

            if (r_state == S_SCAN)
                r_scan_ptr <= (r_scan_ptr == 5'(NUM_BANKS - 1)) ? 5'd0 : r_scan_ptr + 5'd1;

            if (r_state == S_LATCH && w_bad_addr) r_err_addr <= 1'b1;
            else if (err_clr)                     r_err_addr <= 1'b0;

            if (r_state == S_ACK && w_ack_expire) r_err_timeout <= 1'b1;
            else if (err_clr)                     r_err_timeout <= 1'b0;
        end
    end

    always_comb begin
        fpga_ready = (r_state == S_IDLE) && !rst;
        fpga_ack   = 1'b0;
        data_oe    = 1'b0;
        bank_sel   = '0;
        bank_wr    = 1'b0;
        bank_wdata = '0;
        sample_en  = 1'b0;
        case (r_state)
            S_ACCESS: begin
                bank_sel   = r_addr;
                bank_wr    = r_we;
                bank_wdata = r_wdata;
            end
            S_ACK: begin
                fpga_ack = 1'b1;
                data_oe  = !r_we;
            end
            S_SCAN: begin
                sample_en = 1'b1;
                bank_sel  = r_scan_ptr;
            end
            default: ;
        endcase
    end

    assign data_out    = r_data_out;
    assign err_addr    = r_err_addr;
    assign err_timeout = r_err_timeout;
endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Directed bench for bus_xfer_ctrl: transfers, address error, scan cadence, scan/request collision, timeout, reset abort.
// Outputs are sampled just after the falling edge; a negedge monitor counts bank strobes.
module tb_bus_xfer_ctrl;
    logic       CLK50 = 1'b0;
    logic       rst, mcu_mstr, write_enable, err_clr;
    logic [4:0] address, bank_sel;
    logic [7:0] data_in, data_out, bank_wdata, bank_rdata;
    logic       data_oe, fpga_ready, fpga_ack, bank_wr, sample_en, err_addr, err_timeout;

    logic [7:0] in_bank [0:31];
    assign bank_rdata = in_bank[bank_sel];

    bus_xfer_ctrl dut (
        .CLK50(CLK50), .rst(rst), .mcu_mstr(mcu_mstr), .address(address),
        .write_enable(write_enable), .data_in(data_in), .data_out(data_out),
        .data_oe(data_oe), .fpga_ready(fpga_ready), .fpga_ack(fpga_ack),
        .bank_sel(bank_sel), .bank_wr(bank_wr), .bank_wdata(bank_wdata),
        .bank_rdata(bank_rdata), .sample_en(sample_en), .err_clr(err_clr),
        .err_addr(err_addr), .err_timeout(err_timeout)
    );

    always #10 CLK50 = ~CLK50;

    int n_chk = 0, n_pass = 0;
    int cyc = 0, wr_cnt = 0, smp_cnt = 0, overlap = 0, last_wr_cyc = 0, last_smp_cyc = 0;
    logic [4:0] last_wr_sel = '0;
    logic [7:0] last_wr_dat = '0;
    logic [4:0] smp_sel [$];

    always @(negedge CLK50) begin
        cyc++;
        if (bank_wr) begin
            wr_cnt++; last_wr_sel = bank_sel; last_wr_dat = bank_wdata; last_wr_cyc = cyc;
        end
        if (sample_en) begin
            smp_cnt++; smp_sel.push_back(bank_sel); last_smp_cyc = cyc;
        end
        if (bank_wr && sample_en) overlap++;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(negedge CLK50); #1; end
    endtask

    task automatic do_reset();
        rst = 1'b1; mcu_mstr = 1'b0; err_clr = 1'b0;
        repeat (2) @(posedge CLK50);
        @(negedge CLK50); #1;
        rst = 1'b0;
    endtask

    int         lat, rel;
    logic       oe_at_ack, oe_after;
    logic [7:0] dout_at_ack;

    // Raise the request, wait (bounded) for ack, capture read-side outputs, release, wait for ack to drop.
    task automatic xfer(input string tag, input logic [4:0] a, input logic we, input logic [7:0] wd);
        int n;
        address = a; write_enable = we; data_in = wd; mcu_mstr = 1'b1;
        n = 0;
        do begin tick(1); n++; end while (!fpga_ack && n < 40);
        check_val({tag, "_ack_seen"}, fpga_ack, 1);
        lat = n; oe_at_ack = data_oe; dout_at_ack = data_out;
        mcu_mstr = 1'b0;
        n = 0;
        do begin tick(1); n++; end while (fpga_ack && n < 40);
        check_val({tag, "_ack_rel"}, fpga_ack, 0);
        rel = n; oe_after = data_oe;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int wr0, smp0;

    initial begin
        for (int i = 0; i < 32; i++) in_bank[i] = 8'(i * 3 + 1);
        in_bank[16] = 8'h3C;
        address = '0; write_enable = 1'b0; data_in = '0;
        rst = 1'b1; mcu_mstr = 1'b0; err_clr = 1'b0;

        // Reset state
        repeat (2) @(posedge CLK50);
        @(negedge CLK50); #1;
        check_val("rst_ready", fpga_ready, 0);
        check_val("rst_ack", fpga_ack, 0);
        check_val("rst_dout", data_out, 8'h00);
        check_val("rst_wr_smp", {bank_wr, sample_en, data_oe}, 3'b000);
        check_val("rst_errs", {err_addr, err_timeout}, 2'b00);
        rst = 1'b0;
        tick(1);
        check_val("ready_after_rst", fpga_ready, 1);

        // Write addr 5, 0xA5
        wr0 = wr_cnt;
        xfer("wr5", 5'd5, 1'b1, 8'hA5);
        check_val("wr5_latency", lat, 5);
        check_val("wr5_release", rel, 3);
        check_val("wr5_count", wr_cnt - wr0, 1);
        check_val("wr5_sel", last_wr_sel, 5'd5);
        check_val("wr5_data", last_wr_dat, 8'hA5);
        check_val("wr5_oe", oe_at_ack, 0);

        // Read addr 16
        wr0 = wr_cnt;
        xfer("rd16", 5'd16, 1'b0, 8'h00);
        check_val("rd16_dout", dout_at_ack, 8'h3C);
        check_val("rd16_oe_ack", oe_at_ack, 1);
        check_val("rd16_oe_after", oe_after, 0);
        check_val("rd16_no_wr", wr_cnt - wr0, 0);

        // Read addr 20: out of range
        wr0 = wr_cnt;
        xfer("rd20", 5'd20, 1'b0, 8'h00);
        check_val("rd20_err", err_addr, 1);
        check_val("rd20_dout", dout_at_ack, 8'h00);
        check_val("rd20_no_wr", wr_cnt - wr0, 0);
        err_clr = 1'b1; tick(1); err_clr = 1'b0;
        check_val("rd20_err_clr", err_addr, 0);

        // Idle scan cadence and pointer wrap
        do_reset();
        smp0 = smp_cnt; smp_sel.delete();
        tick(17 * 64 + 4);
        check_val("scan_count17", smp_cnt - smp0, 17);
        check_val("scan_first_sel", (smp_sel.size() > 0) ? smp_sel[0] : 5'h1F, 5'd0);
        check_val("scan_17th_sel", (smp_sel.size() > 16) ? smp_sel[16] : 5'h1F, 5'd16);
        tick(64);
        check_val("scan_wrap_sel", (smp_sel.size() > 17) ? smp_sel[17] : 5'h1F, 5'd0);

        // Request lands on the same IDLE cycle as scan expiry
        do_reset();
        repeat (62) @(posedge CLK50);
        @(negedge CLK50); #1;
        smp0 = smp_cnt; smp_sel.delete(); wr0 = wr_cnt;
        xfer("coll", 5'd3, 1'b1, 8'h5A);
        check_val("coll_latency", lat, 5);
        tick(10);
        check_val("coll_scan_count", smp_cnt - smp0, 1);
        check_val("coll_scan_sel", (smp_sel.size() > 0) ? smp_sel[0] : 5'h1F, 5'd0);
        check_val("coll_wr_first", (wr_cnt - wr0 == 1) && (last_wr_cyc < last_smp_cyc), 1);

        // Ack timeout with request stuck high
        do_reset();
        wr0 = wr_cnt;
        address = 5'd2; write_enable = 1'b1; data_in = 8'h77; mcu_mstr = 1'b1;
        tick(200);
        check_val("tmo_not_yet", err_timeout, 0);
        tick(100);
        check_val("tmo_set", err_timeout, 1);
        check_val("tmo_retry_wr", wr_cnt - wr0, 2);
        check_val("tmo_retry_ack", fpga_ack, 1);
        mcu_mstr = 1'b0;
        tick(5);
        check_val("tmo_ack_drop", fpga_ack, 0);
        err_clr = 1'b1; tick(1); err_clr = 1'b0;
        check_val("tmo_clr", err_timeout, 0);

        // Reset during ACCESS
        do_reset();
        address = 5'd7; write_enable = 1'b1; data_in = 8'hC3; mcu_mstr = 1'b1;
        tick(4);
        check_val("abort_in_access", bank_wr, 1);
        wr0 = wr_cnt;
        rst = 1'b1; mcu_mstr = 1'b0;
        tick(1);
        check_val("abort_outputs", {bank_wr, fpga_ack, fpga_ready}, 3'b000);
        tick(1);
        rst = 1'b0;
        tick(1);
        check_val("abort_ready", fpga_ready, 1);
        tick(10);
        check_val("abort_no_wr", wr_cnt - wr0, 0);
        check_val("abort_no_ack", fpga_ack, 0);

        check_val("no_wr_smp_overlap", overlap, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
